// File: rtl/crc8_pkg.sv
// Shared definitions for the 80-bit payload + 8-bit CRC frame generator and checker.
package crc8_pkg;

  localparam logic [7:0] CRC8_INIT   = 8'hFF;
  localparam int         FRAME_BYTES = 10;
  localparam int         FRAME_W     = 80;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX_DATA = 2'd1,
    RX_CRC  = 2'd2,
    DONE    = 2'd3
  } crc8_state_e;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RX_DATA = 2'd1;
  localparam logic [1:0] ST_RX_CRC  = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // The frame CRC is a plain byte-wise XOR; the final invert undoes the 8'hFF seed.
  function automatic logic [7:0] crc8_byte_update(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/crc_8_check_if.sv
// Byte-stream link from the link receiver into the CRC checker.
interface crc_8_check_if;

  logic       din_valid;
  logic [7:0] din;
  logic       din_sof;

  modport master (output din_valid, output din, output din_sof);
  modport slave  (input  din_valid, input  din, input  din_sof);

endinterface

// File: rtl/crc8_acc.sv
// Byte-serial CRC accumulator with seed/enable and inverted final value.
module crc8_acc
  import crc8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc,
  output logic [7:0] crc
);

  // Accumulator register; init together with en seeds with the current byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= CRC8_INIT;
    end else if (init && en) begin
      acc <= crc8_byte_update(CRC8_INIT, din);
    end else if (init) begin
      acc <= CRC8_INIT;
    end else if (en) begin
      acc <= crc8_byte_update(acc, din);
    end else begin
      acc <= acc;
    end
  end

  assign crc = ~acc;

endmodule

// File: rtl/crc_8_check.sv
// Receive-side frame checker: reassembles 10 payload bytes, compares against the trailing CRC byte.
module crc_8_check
  import crc8_pkg::*;
#(
  parameter int DATA_BYTES = FRAME_BYTES,
  parameter int TIMEOUT    = 255,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  crc_8_check_if.slave         rx,
  output logic [FRAME_W-1:0]   frame_data,
  output logic                 frame_valid,
  output logic                 crc_ok,
  output logic [7:0]           crc_rx,
  output logic [7:0]           crc_calc,
  output logic                 frame_abort,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [1:0]         state_r;
  logic [1:0]         state_s;
  logic [3:0]         cnt_r;
  logic [3:0]         cnt_s;
  logic [TMO_W-1:0]   tmo_r;
  logic [TMO_W-1:0]   tmo_s;
  logic [FRAME_W-1:0] shift_r;
  logic               acc_init_s;
  logic               acc_en_s;
  logic               shift_en_s;
  logic               finish_s;
  logic               abort_s;
  logic               sof_s;
  logic [7:0]         acc_s;
  logic [7:0]         crc_s;
  logic               crc_bad_s;

  assign sof_s     = rx.din_valid & rx.din_sof;
  assign crc_bad_s = finish_s & (crc_s != rx.din);

  crc8_acc u_acc (
    .clk  (clk),
    .rst  (rst),
    .init (acc_init_s),
    .en   (acc_en_s),
    .din  (rx.din),
    .acc  (acc_s),
    .crc  (crc_s)
  );

  // Next-state and datapath control; an SOF always wins over a timeout in the same cycle.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    tmo_s      = tmo_r;
    acc_init_s = 1'b0;
    acc_en_s   = 1'b0;
    shift_en_s = 1'b0;
    finish_s   = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (sof_s) begin
          acc_init_s = 1'b1;
          acc_en_s   = 1'b1;
          shift_en_s = 1'b1;
          cnt_s      = 4'd1;
          tmo_s      = '0;
          state_s    = ST_RX_DATA;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RX_DATA, ST_RX_CRC: begin
        if (sof_s) begin
          abort_s    = 1'b1;
          acc_init_s = 1'b1;
          acc_en_s   = 1'b1;
          shift_en_s = 1'b1;
          cnt_s      = 4'd1;
          tmo_s      = '0;
          state_s    = ST_RX_DATA;
        end else if (rx.din_valid) begin
          tmo_s = '0;
          if (state_r == ST_RX_DATA) begin
            acc_en_s   = 1'b1;
            shift_en_s = 1'b1;
            cnt_s      = cnt_r + 4'd1;
            if (cnt_r == 4'(DATA_BYTES - 1)) begin
              state_s = ST_RX_CRC;
            end else begin
              state_s = ST_RX_DATA;
            end
          end else begin
            finish_s = 1'b1;
            cnt_s    = 4'd0;
            state_s  = ST_DONE;
          end
        end else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
          abort_s    = 1'b1;
          acc_init_s = 1'b1;
          cnt_s      = 4'd0;
          tmo_s      = '0;
          state_s    = ST_IDLE;
        end else begin
          tmo_s = tmo_r + TMO_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
        tmo_s   = '0;
      end
    endcase
  end

  // FSM, counters and payload shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      tmo_r   <= '0;
      shift_r <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      tmo_r   <= tmo_s;
      if (shift_en_s) begin
        shift_r <= {shift_r[FRAME_W-9:0], rx.din};
      end else begin
        shift_r <= shift_r;
      end
    end
  end

  // Result outputs are captured as the CRC byte is accepted, so they show in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      crc_ok      <= 1'b0;
      crc_rx      <= 8'h00;
      crc_calc    <= 8'h00;
      frame_abort <= 1'b0;
      busy        <= 1'b0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= finish_s;
      frame_abort <= abort_s;
      busy        <= (state_s == ST_RX_DATA) || (state_s == ST_RX_CRC);
      if (finish_s) begin
        frame_data <= shift_r;
        crc_rx     <= rx.din;
        crc_calc   <= crc_s;
        crc_ok     <= (crc_s == rx.din);
      end else begin
        frame_data <= frame_data;
        crc_rx     <= crc_rx;
        crc_calc   <= crc_calc;
        crc_ok     <= crc_ok;
      end
      if ((crc_bad_s || abort_s) && (err_cnt != {ERR_CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end else begin
        err_cnt <= err_cnt;
      end
    end
  end

endmodule

// File: tb/tb_crc_8_check.sv
// Directed self-checking bench for crc_8_check with a narrow-counter instance for saturation.
module tb_crc_8_check;
  import crc8_pkg::*;

  logic clk;
  logic rst;
  crc_8_check_if bus ();

  logic [79:0] frame_data;
  logic        frame_valid, crc_ok, frame_abort, busy;
  logic [7:0]  crc_rx, crc_calc;
  logic [15:0] err_cnt;

  logic [79:0] s_frame_data;
  logic        s_frame_valid, s_crc_ok, s_frame_abort, s_busy;
  logic [7:0]  s_crc_rx, s_crc_calc;
  logic [1:0]  s_err_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_fv  = 0;
  int n_ab  = 0;

  localparam logic [79:0] P_SEQ = 80'h0102030405060708090A;

  crc_8_check dut (
    .clk(clk), .rst(rst), .rx(bus),
    .frame_data(frame_data), .frame_valid(frame_valid), .crc_ok(crc_ok),
    .crc_rx(crc_rx), .crc_calc(crc_calc), .frame_abort(frame_abort),
    .busy(busy), .err_cnt(err_cnt)
  );

  crc_8_check #(.ERR_CNT_W(2)) sat (
    .clk(clk), .rst(rst), .rx(bus),
    .frame_data(s_frame_data), .frame_valid(s_frame_valid), .crc_ok(s_crc_ok),
    .crc_rx(s_crc_rx), .crc_calc(s_crc_calc), .frame_abort(s_frame_abort),
    .busy(s_busy), .err_cnt(s_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) n_fv++;
    if (frame_abort === 1'b1) n_ab++;
  end

  task automatic drive(input logic [7:0] b, input logic sof);
    bus.din_valid = 1'b1;
    bus.din       = b;
    bus.din_sof   = sof;
    @(negedge clk);
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_payload(input logic [79:0] p, input int nbytes);
    for (int i = 0; i < nbytes; i++) drive(p[79-8*i -: 8], (i == 0));
  endtask

  task automatic send_frame(input logic [79:0] p, input logic [7:0] c);
    send_payload(p, 10);
    drive(c, 1'b0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (frame_data !== 80'h0) begin n_err++; $display("FAIL reset_frame_data: got %h want 0", frame_data); end
    n_cmp++; if ({frame_valid, crc_ok, frame_abort, busy} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {frame_valid, crc_ok, frame_abort, busy}); end
    n_cmp++; if ({crc_rx, crc_calc} !== 16'h0000) begin n_err++; $display("FAIL reset_crc: got %h want 0000", {crc_rx, crc_calc}); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_good_frame();
    apply_reset();
    drive(8'h01, 1'b1);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL good_busy: got %b want 1", busy); end
    for (int i = 1; i < 10; i++) drive(P_SEQ[79-8*i -: 8], 1'b0);
    n_cmp++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL good_early_valid: got %b want 0", frame_valid); end
    drive(8'h0B, 1'b0);
    n_cmp++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL good_valid_latency: got %b want 1", frame_valid); end
    n_cmp++; if (crc_ok !== 1'b1) begin n_err++; $display("FAIL good_crc_ok: got %b want 1", crc_ok); end
    n_cmp++; if (crc_calc !== 8'h0B) begin n_err++; $display("FAIL good_crc_calc: got %h want 0b", crc_calc); end
    n_cmp++; if (frame_data !== P_SEQ) begin n_err++; $display("FAIL good_frame_data: got %h want %h", frame_data, P_SEQ); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL good_err_cnt: got %0d want 0", err_cnt); end
    idle(1);
    n_cmp++; if ({frame_valid, busy} !== 2'b00) begin n_err++; $display("FAIL good_after_done: got %b want 00", {frame_valid, busy}); end
  endtask

  task automatic test_bad_crc();
    apply_reset();
    send_frame(P_SEQ, 8'h0C);
    n_cmp++; if ({frame_valid, crc_ok} !== 2'b10) begin n_err++; $display("FAIL bad_valid_ok: got %b want 10", {frame_valid, crc_ok}); end
    n_cmp++; if (crc_rx !== 8'h0C) begin n_err++; $display("FAIL bad_crc_rx: got %h want 0c", crc_rx); end
    n_cmp++; if (crc_calc !== 8'h0B) begin n_err++; $display("FAIL bad_crc_calc: got %h want 0b", crc_calc); end
    idle(1);
    n_cmp++; if (err_cnt !== 16'd1) begin n_err++; $display("FAIL bad_err_cnt: got %0d want 1", err_cnt); end
  endtask

  task automatic test_back_to_back();
    int fv0;
    apply_reset();
    fv0 = n_fv;
    send_frame({80{1'b1}}, 8'h00);
    n_cmp++; if ({frame_valid, crc_ok} !== 2'b11) begin n_err++; $display("FAIL b2b_first: got %b want 11", {frame_valid, crc_ok}); end
    n_cmp++; if (frame_data !== {80{1'b1}}) begin n_err++; $display("FAIL b2b_first_data: got %h want all ones", frame_data); end
    send_frame(80'h0, 8'h00);
    n_cmp++; if ({frame_valid, crc_ok} !== 2'b11) begin n_err++; $display("FAIL b2b_second: got %b want 11", {frame_valid, crc_ok}); end
    n_cmp++; if (frame_data !== 80'h0) begin n_err++; $display("FAIL b2b_second_data: got %h want 0", frame_data); end
    idle(2);
    n_cmp++; if (n_fv - fv0 !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d want 2", n_fv - fv0); end
    n_cmp++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL b2b_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_mid_sof();
    int fv0, ab0;
    apply_reset();
    fv0 = n_fv;
    ab0 = n_ab;
    send_payload(80'hA1A2A3A4000000000000, 4);
    drive(8'h01, 1'b1);
    n_cmp++; if ({frame_abort, busy} !== 2'b11) begin n_err++; $display("FAIL midsof_abort: got %b want 11", {frame_abort, busy}); end
    for (int i = 1; i < 10; i++) drive(P_SEQ[79-8*i -: 8], 1'b0);
    drive(8'h0B, 1'b0);
    n_cmp++; if ({frame_valid, crc_ok} !== 2'b11) begin n_err++; $display("FAIL midsof_second: got %b want 11", {frame_valid, crc_ok}); end
    n_cmp++; if (frame_data !== P_SEQ) begin n_err++; $display("FAIL midsof_data: got %h want %h", frame_data, P_SEQ); end
    idle(2);
    n_cmp++; if ((n_ab - ab0) !== 1 || (n_fv - fv0) !== 1) begin n_err++; $display("FAIL midsof_pulses: got abort %0d valid %0d want 1 1", n_ab - ab0, n_fv - fv0); end
    n_cmp++; if (err_cnt !== 16'd1) begin n_err++; $display("FAIL midsof_err_cnt: got %0d want 1", err_cnt); end
  endtask

  task automatic test_timeout();
    int early, fv0;
    apply_reset();
    send_frame(P_SEQ, 8'h0B);
    idle(1);
    send_payload(80'h55667700000000000000, 3);
    early = 0;
    for (int k = 1; k < 255; k++) begin
      idle(1);
      if (frame_abort !== 1'b0 || busy !== 1'b1) early++;
    end
    n_cmp++; if (early !== 0) begin n_err++; $display("FAIL tmo_early: got %0d bad cycles want 0", early); end
    idle(1);
    n_cmp++; if ({frame_abort, busy} !== 2'b10) begin n_err++; $display("FAIL tmo_abort: got %b want 10", {frame_abort, busy}); end
    n_cmp++; if ({frame_data, crc_ok} !== {P_SEQ, 1'b1}) begin n_err++; $display("FAIL tmo_hold: got %h %b want %h 1", frame_data, crc_ok, P_SEQ); end
    n_cmp++; if (err_cnt !== 16'd1) begin n_err++; $display("FAIL tmo_err_cnt: got %0d want 1", err_cnt); end
    fv0 = n_fv;
    for (int i = 0; i < 12; i++) drive(8'h0B, 1'b0);
    idle(2);
    n_cmp++; if (busy !== 1'b0 || n_fv !== fv0) begin n_err++; $display("FAIL tmo_stray: got busy %b pulses %0d want 0 0", busy, n_fv - fv0); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    send_frame(P_SEQ, 8'h0C);
    idle(1);
    send_payload(80'h11223344556677000000, 7);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({frame_data, crc_rx, crc_calc} !== 96'h0) begin n_err++; $display("FAIL rstmid_data: got %h want 0", {frame_data, crc_rx, crc_calc}); end
    n_cmp++; if ({err_cnt, busy, crc_ok} !== 18'h0) begin n_err++; $display("FAIL rstmid_status: got %h want 0", {err_cnt, busy, crc_ok}); end
    @(negedge clk);
    rst = 1'b0;
    send_frame(P_SEQ, 8'h0B);
    n_cmp++; if ({frame_valid, crc_ok} !== 2'b11 || err_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_clean: got %b err %0d want 11 err 0", {frame_valid, crc_ok}, err_cnt); end
  endtask

  task automatic test_err_saturation();
    logic [1:0] want [4];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3;
    apply_reset();
    for (int f = 0; f < 4; f++) begin
      send_frame(P_SEQ, 8'h0C);
      idle(1);
      n_cmp++; if (s_err_cnt !== want[f]) begin n_err++; $display("FAIL sat_err_cnt_%0d: got %0d want %0d", f, s_err_cnt, want[f]); end
    end
    n_cmp++; if (err_cnt !== 16'd4) begin n_err++; $display("FAIL sat_wide_err_cnt: got %0d want 4", err_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    bus.din_valid = 1'b0;
    bus.din       = 8'h00;
    bus.din_sof   = 1'b0;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_back_to_back();
    test_mid_sof();
    test_timeout();
    test_reset_mid_frame();
    test_err_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
